// File: rtl/traffic_signal_monitor.sv
// Checks the four signal-head buses for rotation order, colour legality, conflicts and dwell time, and counts completed rotations.
// Latency: a bus sample taken at edge k appears on every output after edge k+1.
// Backpressure: none. This is a passive observer that samples every cycle. Dwell checking is compiled in with TLM_TIMING_CHECK_EN.
module traffic_signal_monitor #(
  parameter int GREEN_CYCLES  = 3,
  parameter int YELLOW_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] HighwayN,
  input  logic [6:0] CityE,
  input  logic [6:0] HighwayS,
  input  logic [6:0] CityW,
  input  logic       clr_faults,
  output logic [1:0] color_hn,
  output logic [1:0] color_ce,
  output logic [1:0] color_hs,
  output logic [1:0] color_cw,
  output logic [1:0] active_dir,
  output logic       active_valid,
  output logic       locked,
  output logic       fault_conflict,
  output logic       fault_code,
  output logic       fault_order,
  output logic       fault_timing,
  output logic [7:0] rotations
);

  localparam logic [6:0] PAT_R = 7'b1110111;
  localparam logic [6:0] PAT_Y = 7'b0110011;
  localparam logic [6:0] PAT_G = 7'b1011111;
  localparam logic [1:0] C_RED = 2'b00;
  localparam logic [1:0] C_YEL = 2'b01;
  localparam logic [1:0] C_GRN = 2'b10;
  localparam logic [1:0] C_INV = 2'b11;

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [6:0]      s1_hn, s1_ce, s1_hs, s1_cw;
  logic [3:0][1:0] col;
  logic [2:0]      nonred_cnt;
  logic            any_inv;
  logic [1:0]      hit_dir;
  logic            sample_valid;
  logic [2:0]      phase_new, phase_q, phase_d;
  logic [7:0]      rot_d;
  logic            set_conflict, set_order, set_timing;

  function automatic logic [1:0] decode(input logic [6:0] p);
    case (p)
      PAT_R:   decode = C_RED;
      PAT_Y:   decode = C_YEL;
      PAT_G:   decode = C_GRN;
      default: decode = C_INV;
    endcase
  endfunction

  // Stage 1: capture the raw buses; reset looks like all-red
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_hn <= PAT_R;
      s1_ce <= PAT_R;
      s1_hs <= PAT_R;
      s1_cw <= PAT_R;
    end else begin
      s1_hn <= HighwayN;
      s1_ce <= CityE;
      s1_hs <= HighwayS;
      s1_cw <= CityW;
    end
  end

  assign col[0] = decode(s1_hn);
  assign col[1] = decode(s1_ce);
  assign col[2] = decode(s1_hs);
  assign col[3] = decode(s1_cw);

  // Count non-red approaches, spot illegal codes and find the active approach
  always_comb begin
    nonred_cnt = '0;
    any_inv    = 1'b0;
    hit_dir    = '0;
    for (int i = 0; i < 4; i++) begin
      if (col[i] == C_INV) begin
        any_inv = 1'b1;
      end else if (col[i] != C_RED) begin
        nonred_cnt = nonred_cnt + 3'd1;
        hit_dir    = 2'(i);
      end
    end
  end

  assign sample_valid = !any_inv && (nonred_cnt == 3'd1);
  assign phase_new    = {hit_dir, (col[hit_dir] == C_YEL)};

`ifdef TLM_TIMING_CHECK_EN
  // dwell_chk is clear while the phase we locked onto is still showing;
  // its length is unknown, so it is not judged.
  logic [3:0] dwell_q, dwell_d;
  logic       dwell_chk_q, dwell_chk_d;
  logic [3:0] dwell_req;
  logic [4:0] dwell_over;
  assign dwell_req  = phase_q[0] ? 4'(YELLOW_CYCLES) : 4'(GREEN_CYCLES);
  assign dwell_over = {1'b0, dwell_req} + 5'd1;
`endif

  // Monitor FSM: lock onto the rotation, follow phases, flag violations
  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    rot_d        = rotations;
    set_conflict = 1'b0;
    set_order    = 1'b0;
    set_timing   = 1'b0;
`ifdef TLM_TIMING_CHECK_EN
    dwell_d      = dwell_q;
    dwell_chk_d  = dwell_chk_q;
`endif
    case (state_q)
      IDLE: begin
        if (sample_valid) begin
          state_d = LOCK;
          phase_d = phase_new;
`ifdef TLM_TIMING_CHECK_EN
          dwell_d     = 4'd1;
          dwell_chk_d = 1'b0;
`endif
        end
      end
      LOCK: begin
        if (any_inv || nonred_cnt > 3'd1) begin
          set_conflict = (nonred_cnt > 3'd1);
          state_d      = IDLE;
`ifdef TLM_TIMING_CHECK_EN
          dwell_d = 4'd0;
`endif
        end else if (nonred_cnt == 3'd0) begin
          set_order = 1'b1;
          state_d   = IDLE;
`ifdef TLM_TIMING_CHECK_EN
          dwell_d = 4'd0;
`endif
        end else if (phase_new != phase_q) begin
          set_order = (phase_new != phase_q + 3'd1);
`ifdef TLM_TIMING_CHECK_EN
          set_timing  = dwell_chk_q && (dwell_q < dwell_req);
          dwell_d     = 4'd1;
          dwell_chk_d = 1'b1;
`endif
          if (!set_order && !set_timing && phase_q == 3'd7 && phase_new == 3'd0) begin
            rot_d = rotations + 8'd1;
          end
          phase_d = phase_new;
        end else begin
`ifdef TLM_TIMING_CHECK_EN
          if (dwell_q != 4'd15) begin
            dwell_d = dwell_q + 4'd1;
          end
          set_timing = dwell_chk_q && ({1'b0, dwell_d} == dwell_over);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Stage 2: register decoded view, FSM state, counters and sticky faults
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      phase_q        <= '0;
      color_hn       <= C_RED;
      color_ce       <= C_RED;
      color_hs       <= C_RED;
      color_cw       <= C_RED;
      active_dir     <= '0;
      active_valid   <= 1'b0;
      fault_conflict <= 1'b0;
      fault_code     <= 1'b0;
      fault_order    <= 1'b0;
      rotations      <= '0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      color_hn       <= col[0];
      color_ce       <= col[1];
      color_hs       <= col[2];
      color_cw       <= col[3];
      active_valid   <= sample_valid;
      if (sample_valid) begin
        active_dir <= hit_dir;
      end
      fault_conflict <= set_conflict | (fault_conflict & ~clr_faults);
      fault_code     <= any_inv      | (fault_code     & ~clr_faults);
      fault_order    <= set_order    | (fault_order    & ~clr_faults);
      rotations      <= rot_d;
    end
  end

  assign locked = (state_q == LOCK);

`ifdef TLM_TIMING_CHECK_EN
  // Dwell tracking and the sticky timing flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_q      <= '0;
      dwell_chk_q  <= 1'b0;
      fault_timing <= 1'b0;
    end else begin
      dwell_q      <= dwell_d;
      dwell_chk_q  <= dwell_chk_d;
      fault_timing <= set_timing | (fault_timing & ~clr_faults);
    end
  end
`else
  assign fault_timing = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_signal_monitor.sv
// Bench for traffic_signal_monitor: directed phase sequences, a sample-history reference model
// compared on every cycle, and hand-computed literal checks at the key points.
module tb_traffic_signal_monitor;

  localparam logic [6:0] R = 7'b1110111;
  localparam logic [6:0] Y = 7'b0110011;
  localparam logic [6:0] G = 7'b1011111;
  localparam int G_REQ = 3;
  localparam int Y_REQ = 2;
`ifdef TLM_TIMING_CHECK_EN
  localparam int TIM_ON = 1;
`else
  localparam int TIM_ON = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] hn = R, ce = R, hs = R, cw = R;
  logic       clr = 1'b0;
  logic [1:0] color_hn, color_ce, color_hs, color_cw, active_dir;
  logic       active_valid, locked;
  logic       fault_conflict, fault_code, fault_order, fault_timing;
  logic [7:0] rotations;

  traffic_signal_monitor #(.GREEN_CYCLES(G_REQ), .YELLOW_CYCLES(Y_REQ)) dut (
    .clk(clk), .rst(rst),
    .HighwayN(hn), .CityE(ce), .HighwayS(hs), .CityW(cw),
    .clr_faults(clr),
    .color_hn(color_hn), .color_ce(color_ce), .color_hs(color_hs), .color_cw(color_cw),
    .active_dir(active_dir), .active_valid(active_valid), .locked(locked),
    .fault_conflict(fault_conflict), .fault_code(fault_code),
    .fault_order(fault_order), .fault_timing(fault_timing),
    .rotations(rotations)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  bit cmp_en    = 0;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: the previous bus sample plus a description of the
  // phase being watched (which approach, which colour, how long it has shown).
  logic [6:0] m_prev [4];
  int m_col [4];
  int m_dir, m_av, m_locked, m_rot;
  int m_fconf, m_fcode, m_ford, m_ftim;
  int m_phase, m_run, m_judged;

  function automatic int colour_of(input logic [6:0] p);
    if (p == R) return 0;
    if (p == Y) return 1;
    if (p == G) return 2;
    return 3;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin m_prev[i] = R; m_col[i] = 0; end
    m_dir = 0; m_av = 0; m_locked = 0; m_rot = 0;
    m_fconf = 0; m_fcode = 0; m_ford = 0; m_ftim = 0;
    m_phase = 0; m_run = 0; m_judged = 0;
  endtask

  task automatic model_edge();
    int lit, bad, who, p, need, nc, nk, no, nt;
    lit = 0; bad = 0; who = 0;
    for (int i = 0; i < 4; i++) begin
      m_col[i] = colour_of(m_prev[i]);
      if (m_col[i] == 3) bad = 1;
      else if (m_col[i] != 0) begin lit++; who = i; end
    end
    nc = 0; nk = bad; no = 0; nt = 0;
    m_av = (!bad && lit == 1) ? 1 : 0;
    if (m_av == 1) m_dir = who;
    p = 2 * who + ((m_col[who] == 1) ? 1 : 0);
    need = (m_phase % 2 == 1) ? Y_REQ : G_REQ;
    if (m_locked == 0) begin
      if (m_av == 1) begin m_locked = 1; m_phase = p; m_run = 1; m_judged = 0; end
    end else if (bad || lit > 1) begin
      nc = (lit > 1) ? 1 : 0; m_locked = 0;
    end else if (lit == 0) begin
      no = 1; m_locked = 0;
    end else if (p != m_phase) begin
      no = (p != (m_phase + 1) % 8) ? 1 : 0;
      if (TIM_ON == 1 && m_judged == 1 && m_run < need) nt = 1;
      if (no == 0 && nt == 0 && m_phase == 7 && p == 0) m_rot = (m_rot + 1) % 256;
      m_phase = p; m_run = 1; m_judged = 1;
    end else begin
      m_run = (m_run < 15) ? m_run + 1 : 15;
      if (TIM_ON == 1 && m_judged == 1 && m_run == need + 1) nt = 1;
    end
    m_fconf = (nc == 1 || (m_fconf == 1 && !clr)) ? 1 : 0;
    m_fcode = (nk == 1 || (m_fcode == 1 && !clr)) ? 1 : 0;
    m_ford  = (no == 1 || (m_ford  == 1 && !clr)) ? 1 : 0;
    m_ftim  = (nt == 1 || (m_ftim  == 1 && !clr)) ? 1 : 0;
    m_prev[0] = hn; m_prev[1] = ce; m_prev[2] = hs; m_prev[3] = cw;
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("color_hn", int'(color_hn), m_col[0]);
      chk("color_ce", int'(color_ce), m_col[1]);
      chk("color_hs", int'(color_hs), m_col[2]);
      chk("color_cw", int'(color_cw), m_col[3]);
      chk("active_dir", int'(active_dir), m_dir);
      chk("active_valid", int'(active_valid), m_av);
      chk("locked", int'(locked), m_locked);
      chk("fault_conflict", int'(fault_conflict), m_fconf);
      chk("fault_code", int'(fault_code), m_fcode);
      chk("fault_order", int'(fault_order), m_ford);
      chk("fault_timing", int'(fault_timing), m_ftim);
      chk("rotations", int'(rotations), m_rot);
    end
  end

  task automatic cyc(input logic [6:0] a, input logic [6:0] b, input logic [6:0] c,
                     input logic [6:0] d, input logic cl);
    hn = a; ce = b; hs = c; cw = d; clr = cl;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic phase(input int dir, input logic [6:0] pat, input int n);
    logic [6:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = (i == dir) ? pat : R;
    for (int k = 0; k < n; k++) cyc(b[0], b[1], b[2], b[3], 1'b0);
  endtask

  task automatic rotation();
    for (int d = 0; d < 4; d++) begin
      phase(d, G, G_REQ);
      phase(d, Y, Y_REQ);
    end
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b1;
    @(negedge clk);
    chk("reset_locked", int'(locked), 0);
    chk("reset_rotations", int'(rotations), 0);
    chk("reset_color_hn", int'(color_hn), 0);
    chk("reset_active_valid", int'(active_valid), 0);
    chk("reset_fault_code", int'(fault_code), 0);
    rst = 1'b0;
    cmp_en = 1;

    // Two legal rotations from HN green
    phase(0, G, 1);
    chk("lock_after_one_edge", int'(locked), 0);
    phase(0, G, 1);
    chk("lock_after_two_edges", int'(locked), 1);
    chk("first_dir", int'(active_dir), 0);
    phase(0, G, G_REQ - 2);
    phase(0, Y, Y_REQ);
    for (int d = 1; d < 4; d++) begin phase(d, G, G_REQ); phase(d, Y, Y_REQ); end
    rotation();
    phase(0, G, 1);
    phase(0, G, 1);
    chk("two_rotations", int'(rotations), 2);
    chk("legal_no_order", int'(fault_order), 0);
    chk("legal_no_timing", int'(fault_timing), 0);
    chk("legal_no_conflict", int'(fault_conflict), 0);

    // Two greens at once
    cyc(G, G, R, R, 1'b0);
    cyc(G, R, R, R, 1'b0);
    chk("conflict_flag", int'(fault_conflict), 1);
    chk("conflict_valid", int'(active_valid), 0);
    chk("conflict_unlock", int'(locked), 0);
    cyc(G, R, R, R, 1'b0);
    chk("conflict_relock", int'(locked), 1);
    cyc(G, R, R, R, 1'b1);
    chk("clr_conflict", int'(fault_conflict), 0);

    // Blank CityW pattern
    cyc(G, R, R, 7'b0000000, 1'b0);
    cyc(G, R, R, R, 1'b0);
    chk("code_color_cw", int'(color_cw), 3);
    chk("code_flag", int'(fault_code), 1);
    chk("code_unlock", int'(locked), 0);
    chk("code_no_conflict", int'(fault_conflict), 0);
    chk("code_no_order", int'(fault_order), 0);
    cyc(G, R, R, R, 1'b1);
    chk("clr_code", int'(fault_code), 0);

    // HN G, HN Y, then a skip to HS G
    phase(0, G, 3);
    phase(0, Y, 2);
    phase(2, G, 1);
    phase(2, G, 1);
    chk("order_flag", int'(fault_order), 1);
    chk("order_locked", int'(locked), 1);
    chk("order_dir", int'(active_dir), 2);
    phase(2, G, 1);
    phase(2, Y, 2);
    phase(3, G, 3);
    phase(3, Y, 2);
    phase(0, G, 1);
    phase(0, G, 1);
    chk("rotation_after_order", int'(rotations), 3);

    // HN G held 4 cycles, then a 1-cycle yellow
    cyc(G, R, R, R, 1'b1);
    chk("clr_order", int'(fault_order), 0);
    cyc(G, R, R, R, 1'b0);
    cyc(Y, R, R, R, 1'b0);
    chk("stuck_green_timing", int'(fault_timing), TIM_ON);
    cyc(R, G, R, R, 1'b0);
    cyc(G, G, R, R, 1'b0);
    // Clear coincident with a new conflict
    cyc(R, G, R, R, 1'b1);
    chk("clr_vs_conflict", int'(fault_conflict), 1);
    chk("clr_timing", int'(fault_timing), 0);
    chk("clr_conflict_unlock", int'(locked), 0);

    // Asynchronous reset in the middle of a rotation
    phase(1, G, 2);
    #2 rst = 1'b1;
    #1;
    chk("arst_locked", int'(locked), 0);
    chk("arst_rotations", int'(rotations), 0);
    chk("arst_color_ce", int'(color_ce), 0);
    chk("arst_fault_conflict", int'(fault_conflict), 0);
    chk("arst_active_valid", int'(active_valid), 0);
    model_reset();
    #1 rst = 1'b0;
    cyc(G, R, R, R, 1'b0);
    cyc(G, R, R, R, 1'b0);
    chk("relock_after_rst", int'(locked), 1);
    chk("rot_after_rst", int'(rotations), 0);

    cmp_en = 0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/traffic_signal_monitor.md
# traffic_signal_monitor

- Receive-side checker for the four seven-segment signal-head buses driven by the traffic light controller.
- Per cycle it decodes each 7-bit pattern to RED/YELLOW/GREEN/INVALID and tracks the active approach.
- It checks the rotation order and the per-phase dwell, raises sticky fault flags and counts completed rotations.
- It sits beside the controller on the signal-head buses, feeding status LEDs or a supervisor.

## Interface
- GREEN_CYCLES, 3, required consecutive cycles a GREEN phase is displayed (1..14)
- YELLOW_CYCLES, 2, required consecutive cycles a YELLOW phase is displayed (1..14)
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- HighwayN, CityE, HighwayS, CityW  in  7 each  segment patterns: R=7'b1110111, Y=7'b0110011, G=7'b1011111
- clr_faults  in  1  synchronous clear of all fault flags
- color_hn, color_ce, color_hs, color_cw  out  2 each  decoded color: 00 red, 01 yellow, 10 green, 11 invalid
- active_dir  out  2  non-red approach: 0 HighwayN, 1 CityE, 2 HighwayS, 3 CityW
- active_valid  out  1  exactly one approach non-red, all codes legal
- locked  out  1  monitor is tracking the rotation
- fault_conflict, fault_code, fault_order, fault_timing  out  1 each  sticky faults
- rotations  out  8  completed rotations, wraps 255->0

## Operation
- Stage 1 registers the four raw buses. Stage 2 decodes, checks, and registers all outputs.
- Any pattern not equal to R/Y/G decodes to 11 and sets fault_code.
- Phase index = 2*dir + (yellow?1:0), giving 0..7.
- Legal successor of phase p is (p+1) mod 8: HN G, HN Y, CE G, CE Y, HS G, HS Y, CW G, CW Y, back to HN G.
- The monitor FSM has two states, IDLE (locked=0) and LOCK (locked=1).
- IDLE -> LOCK on the first sample with active_valid=1. That first phase's dwell is not checked.
- In LOCK, more than one non-red approach sets fault_conflict and returns to IDLE.
- In LOCK, any invalid code sets fault_code and returns to IDLE.
- In LOCK, all four red is treated as an illegal phase: set fault_order and return to IDLE.
- In LOCK, a phase change to anything other than the successor sets fault_order. The FSM stays in LOCK and tracks the new phase.
- A dwell counter (4-bit, saturating at 15) counts consecutive samples of the current phase. It restarts at 1 on each phase change.
- rotations increments on a legal CW Y -> HN G change in LOCK, only when no fault is set on that change.
- Fault flags stay set until rst or clr_faults.
- If clr_faults and a new fault occur in the same cycle, the new fault wins and its flag ends set.

## Timing
- The four buses sampled at edge k are reflected in every output after edge k+1 (two-edge latency).
- Reset values:
  - stage-1 registers = RED pattern
  - color_* = 00, active_dir = 0, active_valid = 0
  - locked = 0, all faults = 0, rotations = 0
  - FSM = IDLE, dwell = 0
- fault_timing is set on the cycle the dwell of a GREEN phase reaches GREEN_CYCLES+1, or of a YELLOW phase reaches YELLOW_CYCLES+1 (stuck light).
- fault_timing is also set on the cycle a phase change occurs with dwell below its required value.
- A phase that both overruns and then changes sets fault_timing only once; the flag is sticky.
- Reset asserted mid-rotation clears everything immediately. Relock needs a fresh valid sample, and rotations restarts at 0.
- A fault_order change still updates active_dir and the dwell reference to the new phase.

## Configuration
- TLM_TIMING_CHECK_EN defined: dwell counter present, fault_timing checks as above.
- TLM_TIMING_CHECK_EN undefined: dwell counter removed, fault_timing tied 0. Order, code and conflict checks are unchanged.

## Test plan
- Legal rotation, 3-cycle greens and 2-cycle yellows starting at HN G after reset, for two full rotations back to HN G:
  - locked=1 two edges after the first sample
  - rotations=2, all faults 0
  - active_dir steps 0,0,1,1,2,2,3,3
- During LOCK, drive HighwayN=G and CityE=G for one cycle:
  - fault_conflict=1, active_valid=0, locked=0
  - relock on the next single-green sample
- CityW=7'b0000000 for one cycle while locked:
  - color_cw=11, fault_code=1, locked=0
  - other faults remain 0
- Sequence HN G (3 cycles), HN Y (2), HS G:
  - fault_order=1, locked stays 1, active_dir=2
  - rotations does not increment on the following CW Y -> HN G if that change carries a fault; otherwise it increments
- Hold HN G for 4 cycles, then YELLOW for 1 cycle:
  - with TLM_TIMING_CHECK_EN, fault_timing=1 appears two edges after the 4th G sample
  - without the macro, fault_timing stays 0
- Assert clr_faults with faults set: all flags 0 next edge.
- Repeat with clr_faults coincident with a new conflict: fault_conflict=1.
- Pulse rst mid-rotation: all outputs return to reset values immediately.
